nanosoc_accel_dma_sched: RTL
============================

Name: nanosoc_accel_dma_sched

Overview:
Schedules the single nanosoc DMA engine between the two accelerator data channels: input feed (ip_data_req) and output drain (op_data_req). Arbitrates between pending requests and issues a per-channel DMA request. Tracks each transfer to completion, with a completion timeout and per-channel block counters. Sits in the expansion region between the accelerator wrapper request outputs and the DMA controller request/done inputs.

Parameters:
TIMEOUT_W, 16, width of timeout counter and timeout_val.
CNT_W, 16, width of per-channel completed-block counters.
HOLDOFF, 2, cycles to wait after dma_done before re-arbitrating; lets accelerator level requests settle. 0 = no wait.

Ports:
HCLK  in  1  clock
HRESET  in  1  reset
sched_en  in  1  permit new grants
ip_data_req  in  1  accelerator input-channel request, level
op_data_req  in  1  accelerator output-channel request, level
dma_active  in  1  DMA engine has accepted a request and is busy
dma_done  in  2  per-channel completion pulse; bit0 = ip, bit1 = op
timeout_val  in  TIMEOUT_W  cycles allowed per transfer; 0 disables the timeout
err_clr  in  1  clears the error state
dma_req  out  2  per-channel DMA request; bit0 = ip, bit1 = op; at most one bit set
busy  out  1  scheduler not in IDLE
cur_ch  out  1  channel granted; 0 = ip, 1 = op
err  out  1  timeout error flag
ip_blk_cnt  out  CNT_W  completed ip transfers
op_blk_cnt  out  CNT_W  completed op transfers

Behaviour:
- Clock and reset: HCLK is the single clock. HRESET is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer last=op, so ip wins the first tie; timeout counter 0.
- All outputs are registered.
- States: IDLE, REQ, XFER, HOLD, ERR.
- IDLE:
  - If sched_en=1 and either request is high, latch the grant into cur_ch and enter REQ.
  - dma_req[cur_ch] rises in the same edge, so the request appears 1 cycle after the input request is sampled.
  - Arbitration: a single requester wins. If both request, grant the channel not served last (round-robin).
- REQ:
  - Hold dma_req[cur_ch]=1 until dma_active=1 is sampled.
  - Then clear dma_req and enter XFER.
- XFER:
  - Wait for dma_done[cur_ch]=1.
  - On done: increment the matching counter, which wraps modulo 2^CNT_W.
  - Update last=cur_ch.
  - Go to HOLD, loading HOLDOFF; go straight to IDLE if HOLDOFF=0.
  - dma_done on the non-granted bit is ignored in every state.
- HOLD:
  - Count down HOLDOFF cycles, then go to IDLE.
  - Requests are not sampled during HOLD.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ and XFER.
  - If timeout_val≠0 and the counter reaches timeout_val: clear dma_req, set err=1, enter ERR.
  - If dma_done[cur_ch] arrives in the same cycle as the timeout, done wins: the counter increments and there is no error.
  - Counter saturates at all-ones.
- ERR:
  - dma_req=0, busy=1, err=1.
  - On err_clr=1, clear err and go to IDLE; last is left unchanged.
  - err_clr outside ERR is ignored.
- sched_en=0 only blocks grants from IDLE. An in-flight REQ or XFER completes normally.
- HRESET asserted mid-transfer returns the block to reset values immediately, including dropping dma_req.
- busy=1 in REQ, XFER, HOLD and ERR.

Optional Feature:
NANOSOC_DMA_SCHED_OP_PRIO_EN
- Defined: fixed priority; op_data_req always wins when both channels request, so the output drain is never starved by the feed. The round-robin pointer is unused.
- Undefined: round-robin as described above.

Test Plan:
- Single ip request: ip_data_req=1, dma_active 2 cycles after dma_req, dma_done[0] 10 cycles later, HOLDOFF=2 -> dma_req=01 one cycle after the request and held until dma_active; cur_ch=0; ip_blk_cnt=1; busy low 3 cycles after done.
- Both requests held high for 4 transfers -> grants ip, op, ip, op; ip_blk_cnt=2, op_blk_cnt=2. With OP_PRIO_EN defined -> op granted all 4.
- timeout_val=20, dma_active returned but no done -> err=1 and dma_req=00 on the 20th REQ+XFER cycle. err_clr pulse -> err=0, IDLE next cycle. Same stimulus with timeout_val=0 -> never errors.
- dma_done[cur_ch] on the exact timeout cycle -> no err; counter increments. dma_done[1] during an ip XFER -> ignored, still waiting.
- sched_en=0 with requests pending -> stays IDLE with dma_req=00. sched_en dropped during XFER -> transfer completes, then no new grant.
- HRESET pulsed while in REQ -> dma_req=00, busy=0, counters 0 asynchronously. op_blk_cnt preloaded via 2^CNT_W-1 transfers (CNT_W=4) -> wraps to 0 on the 16th.

Source files
------------

// File: rtl/nanosoc_accel_dma_sched.sv
// Schedules the single DMA engine between the accelerator ip (feed) and op (drain) channels.
// Optional `NANOSOC_DMA_SCHED_OP_PRIO_EN gives op fixed priority instead of round-robin.
module nanosoc_accel_dma_sched #(
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 16,
    parameter int HOLDOFF   = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 sched_en,
    input  logic                 ip_data_req,
    input  logic                 op_data_req,
    input  logic                 dma_active,
    input  logic [1:0]           dma_done,
    input  logic [TIMEOUT_W-1:0] timeout_val,
    input  logic                 err_clr,
    output logic [1:0]           dma_req,
    output logic                 busy,
    output logic                 cur_ch,
    output logic                 err,
    output logic [CNT_W-1:0]     ip_blk_cnt,
    output logic [CNT_W-1:0]     op_blk_cnt
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

    typedef enum logic [2:0] {IDLE, REQ, XFER, HOLD, ERR} state_t;

    state_t               state, state_nxt;
    logic                 last, last_nxt;
    logic                 cur_ch_nxt, busy_nxt, err_nxt;
    logic [1:0]           dma_req_nxt;
    logic [TIMEOUT_W-1:0] tcnt, tcnt_nxt, tcnt_inc;
    logic [HW-1:0]        hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0]     ip_cnt_nxt, op_cnt_nxt;
    logic                 grant, timeout_hit, done_cur;

`ifdef NANOSOC_DMA_SCHED_OP_PRIO_EN
    assign grant = op_data_req;
`else
    // On a tie the channel not served last wins; a lone requester always wins.
    assign grant = (ip_data_req && op_data_req) ? ~last : op_data_req;
`endif

    assign tcnt_inc    = (&tcnt) ? tcnt : tcnt + TIMEOUT_W'(1);
    assign timeout_hit = (timeout_val != '0) && (tcnt_inc >= timeout_val);
    assign done_cur    = dma_done[cur_ch];

    always_comb begin
        // NOTE: every next value defaults to the current one first, so no path is left unassigned and no latch is inferred.
        state_nxt    = state;
        last_nxt     = last;
        cur_ch_nxt   = cur_ch;
        busy_nxt     = busy;
        err_nxt      = err;
        dma_req_nxt  = dma_req;
        tcnt_nxt     = tcnt;
        hold_cnt_nxt = hold_cnt;
        ip_cnt_nxt   = ip_blk_cnt;
        op_cnt_nxt   = op_blk_cnt;
        case (state)
            IDLE: begin
                if (sched_en && (ip_data_req || op_data_req)) begin
                    state_nxt   = REQ;
                    cur_ch_nxt  = grant;
                    dma_req_nxt = grant ? 2'b10 : 2'b01;
                    busy_nxt    = 1'b1;
                    tcnt_nxt    = '0;
                end
            end
            REQ: begin
                tcnt_nxt = tcnt_inc;
                if (timeout_hit) begin
                    state_nxt   = ERR;
                    dma_req_nxt = 2'b00;
                    err_nxt     = 1'b1;
                end else if (dma_active) begin
                    state_nxt   = XFER;
                    dma_req_nxt = 2'b00;
                end
            end
            XFER: begin
                tcnt_nxt = tcnt_inc;
                // Completion takes precedence over a timeout landing in the same cycle.
                if (done_cur) begin
                    if (cur_ch) op_cnt_nxt = op_blk_cnt + CNT_W'(1);
                    else        ip_cnt_nxt = ip_blk_cnt + CNT_W'(1);
                    last_nxt = cur_ch;
                    if (HOLDOFF == 0) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = HOLD_LOAD;
                    end
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    hold_cnt_nxt = hold_cnt - HW'(1);
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= IDLE;
            last       <= 1'b1;
            cur_ch     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            dma_req    <= 2'b00;
            tcnt       <= '0;
            hold_cnt   <= '0;
            ip_blk_cnt <= '0;
            op_blk_cnt <= '0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            cur_ch     <= cur_ch_nxt;
            busy       <= busy_nxt;
            err        <= err_nxt;
            dma_req    <= dma_req_nxt;
            tcnt       <= tcnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            ip_blk_cnt <= ip_cnt_nxt;
            op_blk_cnt <= op_cnt_nxt;
        end
    end
endmodule
